alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 59 +++++
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer_regfile.sv | 29 ++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: ALU op codes, FSM states and
// the instruction word layout.
package alu_seq_pkg;

  localparam int INSTR_W  = 13;
  localparam int IMM_BIT  = 12;
  localparam int OP_HI    = 11;
  localparam int OP_LO    = 9;
  localparam int CIN_BIT  = 8;
  localparam int RD_HI    = 7;
  localparam int RD_LO    = 6;
  localparam int RA_HI    = 5;
  localparam int RA_LO    = 4;
  localparam int IMM4_HI  = 3;
  localparam int IMM4_LO  = 0;
  localparam int RB_HI    = 1;
  localparam int RB_LO    = 0;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_PASSB = 3'b010,
    OP_PASSA = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_NOTA  = 3'b110,
    OP_XOR   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic       imm;
    logic [2:0] op;
    logic       cin;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [3:0] rb_imm4;
  } instr_t;

  // Build an instruction word from its fields.
  function automatic logic [INSTR_W-1:0] mk_instr(
    input logic       imm,
    input logic [2:0] op,
    input logic       cin,
    input logic [1:0] rd,
    input logic [1:0] ra,
    input logic [3:0] rb_imm4
  );
    return {imm, op, cin, rd, ra, rb_imm4};
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and result handshake bundle of the ALU sequencer.
interface alu_sequencer_if;

  logic                           in_valid;
  logic                           in_ready;
  logic [alu_seq_pkg::INSTR_W-1:0] instr;
  logic [3:0]                     alu_a;
  logic [3:0]                     alu_b;
  logic [2:0]                     alu_s;
  logic                           alu_cin;
  logic [3:0]                     alu_y;
  logic                           out_valid;
  logic                           out_ready;
  logic [3:0]                     out_data;
  logic [1:0]                     out_rd;

  // Sequencer side.
  modport slave (
    input  in_valid, instr, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_s, alu_cin, out_valid, out_data, out_rd
  );

  // Instruction source / result consumer / ALU side.
  modport master (
    output in_valid, instr, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_s, alu_cin, out_valid, out_data, out_rd
  );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// Four 4-bit registers: two combinational read ports, one synchronous
// write port, asynchronous active-low clear.
module regfile_4x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_ra_addr,
  input  logic [1:0] i_rb_addr,
  output logic [3:0] o_ra_data,
  output logic [3:0] o_rb_data,
  input  logic       i_we,
  input  logic [1:0] i_wa,
  input  logic [3:0] i_wd
);

  logic [3:0] r_mem [4];

  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];

  // Clear all entries on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 4'h0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through an external 4-bit ALU:
// fetch operands from the register file, register them to the ALU,
// capture the result, write it back and offer it downstream.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | ready for an instruction, in_ready=1
//   READ    | instruction latched; operands registered to the ALU
//   EXEC    | ALU result captured, written to R[RD], out_valid set
//   DONE    | result held until out_ready, then back to IDLE
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  state_e     r_state;
  instr_t     r_instr;
  logic       r_in_ready;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [2:0] r_alu_s;
  logic       r_alu_cin;
  logic       r_out_valid;
  logic [3:0] r_out_data;
  logic [1:0] r_out_rd;

  instr_t     w_instr;
  logic [3:0] w_ra_data;
  logic [3:0] w_rb_data;
  logic       w_we;

  assign w_instr = instr_t'(bus.instr);
  // Write-back happens on the EXEC edge, so READ always sees the old value.
  assign w_we    = (r_state == ST_EXEC);

  regfile_4x4 u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ra_addr (r_instr.ra),
    .i_rb_addr (r_instr.rb_imm4[RB_HI:RB_LO]),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .i_we      (w_we),
    .i_wa      (r_instr.rd),
    .i_wd      (bus.alu_y)
  );

  // Sequencer FSM with all handshake and ALU outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_instr     <= '0;
      r_in_ready  <= 1'b1;
      r_alu_a     <= 4'h0;
      r_alu_b     <= 4'h0;
      r_alu_s     <= 3'b000;
      r_alu_cin   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_rd    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_instr    <= w_instr;
            r_in_ready <= 1'b0;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          r_alu_a   <= w_ra_data;
          r_alu_b   <= r_instr.imm ? r_instr.rb_imm4 : w_rb_data;
          r_alu_s   <= r_instr.op;
          r_alu_cin <= r_instr.cin;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          r_out_data  <= bus.alu_y;
          r_out_rd    <= r_instr.rd;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_s     = r_alu_s;
  assign bus.alu_cin   = r_alu_cin;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_rd    = r_out_rd;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_sequencer_if bus ();

  alu_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: SUB is A + ~B + CIN, so CIN=1 means no borrow.
  function automatic logic [3:0] alu_model(input logic [2:0] s, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
    logic [4:0] t;
    case (s)
      OP_ADD:   t = {1'b0, a} + {1'b0, b} + {4'h0, cin};
      OP_SUB:   t = {1'b0, a} + {1'b0, ~b} + {4'h0, cin};
      OP_PASSB: t = {1'b0, b};
      OP_PASSA: t = {1'b0, a};
      OP_AND:   t = {1'b0, a & b};
      OP_OR:    t = {1'b0, a | b};
      OP_NOTA:  t = {1'b0, ~a};
      default:  t = {1'b0, a ^ b};
    endcase
    return t[3:0];
  endfunction

  assign bus.alu_y = alu_model(bus.alu_s, bus.alu_a, bus.alu_b, bus.alu_cin);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then offer one instruction for one edge.
  // Returns at the negedge after the accepting edge.
  task automatic issue(input logic [12:0] ins);
    int t;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("issue_in_ready", {7'd0, bus.in_ready}, 8'd1);
    bus.instr    = ins;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Full instruction with out_ready already high.
  task automatic run(input string tag, input logic [12:0] ins,
                     input logic [3:0] exp_y, input logic [1:0] exp_rd);
    issue(ins);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {7'd0, bus.out_valid}, 8'd1);
    check({tag, "_data"},  {4'd0, bus.out_data},  {4'd0, exp_y});
    check({tag, "_rd"},    {6'd0, bus.out_rd},    {6'd0, exp_rd});
    @(negedge clk);
    check({tag, "_idle"},  {6'd0, bus.in_ready, bus.out_valid}, 8'b10);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {7'd0, bus.in_ready},  8'd1);
    check("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    check("rst_alu_a",     {4'd0, bus.alu_a},     8'd0);
    check("rst_alu_b",     {4'd0, bus.alu_b},     8'd0);
    check("rst_alu_s_cin", {4'd0, bus.alu_s, bus.alu_cin}, 8'd0);
    check("rst_out_data",  {4'd0, bus.out_data},  8'd0);
    check("rst_out_rd",    {6'd0, bus.out_rd},    8'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready",  {7'd0, bus.in_ready},  8'd1);
    check("rel_out_valid", {7'd0, bus.out_valid}, 8'd0);

    // Load immediate with latency checks: R1 = 5
    issue(mk_instr(1'b1, OP_PASSB, 1'b0, 2'd1, 2'd0, 4'h5));
    check("load_n0", {6'd0, bus.out_valid, bus.in_ready}, 8'd0);
    @(negedge clk);
    check("load_n1_valid", {7'd0, bus.out_valid}, 8'd0);
    check("load_n1_alu_b", {4'd0, bus.alu_b}, 8'h05);
    check("load_n1_alu_s", {5'd0, bus.alu_s}, 8'h02);
    @(negedge clk);
    check("load_n2_valid", {7'd0, bus.out_valid}, 8'd1);
    check("load_n2_data",  {4'd0, bus.out_data},  8'h05);
    check("load_n2_rd",    {6'd0, bus.out_rd},    8'd1);
    check("load_r1",       {4'd0, u_dut.u_rf.r_mem[1]}, 8'h05);
    @(negedge clk);
    check("load_n3_idle",  {6'd0, bus.in_ready, bus.out_valid}, 8'b10);

    // Add with wrap: R3 preset to 9 so the write of 0 is visible
    run("ld_r3", mk_instr(1'b1, OP_PASSB, 1'b0, 2'd3, 2'd0, 4'h9), 4'h9, 2'd3);
    run("ld_r1", mk_instr(1'b1, OP_PASSB, 1'b0, 2'd1, 2'd0, 4'hF), 4'hF, 2'd1);
    run("ld_r2", mk_instr(1'b1, OP_PASSB, 1'b0, 2'd2, 2'd0, 4'h1), 4'h1, 2'd2);
    run("addw",  mk_instr(1'b0, OP_ADD,   1'b0, 2'd3, 2'd1, 4'h2), 4'h0, 2'd3);
    check("addw_r3", {4'd0, u_dut.u_rf.r_mem[3]}, 8'h00);

    // Subtract immediate: 7 - 3 with CIN=1 -> 4 into R0
    run("ld_r1b", mk_instr(1'b1, OP_PASSB, 1'b0, 2'd1, 2'd0, 4'h7), 4'h7, 2'd1);
    run("sub",    mk_instr(1'b1, OP_SUB,   1'b1, 2'd0, 2'd1, 4'h3), 4'h4, 2'd0);
    check("sub_alu_s",   {5'd0, bus.alu_s},   8'h01);
    check("sub_alu_cin", {7'd0, bus.alu_cin}, 8'd1);
    check("sub_alu_ab",  {bus.alu_a, bus.alu_b}, 8'h73);
    check("sub_r0",      {4'd0, u_dut.u_rf.r_mem[0]}, 8'h04);

    // Backpressure: R2 = R0 ^ A = E, held for 3 cycles with in_valid pushing
    bus.out_ready = 1'b0;
    issue(mk_instr(1'b1, OP_XOR, 1'b0, 2'd2, 2'd0, 4'hA));
    @(negedge clk);
    @(negedge clk);
    bus.instr    = mk_instr(1'b1, OP_PASSB, 1'b0, 2'd0, 2'd0, 4'h1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", {7'd0, bus.out_valid}, 8'd1);
      check("bp_hold_data",  {4'd0, bus.out_data},  8'h0E);
      check("bp_hold_ready", {7'd0, bus.in_ready},  8'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {6'd0, bus.in_ready, bus.out_valid}, 8'b10);
    check("bp_r0_kept", {4'd0, u_dut.u_rf.r_mem[0]}, 8'h04);

    // RD == RA == RB: reads old 7, writes F; next instruction sees F
    run("haz", mk_instr(1'b0, OP_ADD, 1'b1, 2'd1, 2'd1, 4'h1), 4'hF, 2'd1);
    check("haz_alu_ab", {bus.alu_a, bus.alu_b}, 8'h77);
    run("haz_next", mk_instr(1'b0, OP_PASSA, 1'b0, 2'd3, 2'd1, 4'h0), 4'hF, 2'd3);
    repeat (2) @(negedge clk);
    check("idle_alu_hold", {bus.alu_a, 1'b0, bus.alu_s}, 8'hF3);

    // Reset while in EXEC: no result, target register cleared and not written
    issue(mk_instr(1'b1, OP_PASSB, 1'b0, 2'd2, 2'd0, 4'h9));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstx_valid", {7'd0, bus.out_valid}, 8'd0);
    check("rstx_ready", {7'd0, bus.in_ready},  8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstx_no_pulse", {7'd0, bus.out_valid}, 8'd0);
    end
    check("rstx_r2", {4'd0, u_dut.u_rf.r_mem[2]}, 8'h00);

    // Logic ops on the cleared file: R1 = 0 | 6, R0 = ~R1
    run("or",   mk_instr(1'b1, OP_OR,   1'b0, 2'd1, 2'd1, 4'h6), 4'h6, 2'd1);
    run("nota", mk_instr(1'b0, OP_NOTA, 1'b0, 2'd0, 2'd1, 4'h0), 4'h9, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
